fetch_unit: RTL

Instruction fetch stage of the 5-stage pipeline. It owns the PC, issues in-order word fetches to instruction memory over a request/response handshake that tolerates variable latency, and buffers up to two returned instructions. It presents one instruction per cycle (InstrF, PCF, PCPlus4F) to the IF/ID pipeline register. It honours the hazard unit's StallF and the EX-stage branch/jump redirect.

---
 rtl/fetch_unit.sv | 90 +++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, streams word fetches over a variable-latency
// request/response port and presents one buffered instruction per cycle to IF/ID.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_StallF,
  input  logic        i_PCSrcE,
  input  logic [31:0] i_PCTargetE,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ready,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_InstrF,
  output logic [31:0] o_PCF,
  output logic [31:0] o_PCPlus4F,
  output logic        o_InstrValidF
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fent_t;

  logic [31:0] r_pc_req, r_pc_resp;
  logic [1:0]  r_inflight, r_drop, r_cnt;
  fent_t       r_fifo [2];

  logic        w_valid, w_pop, w_rsp, w_push, w_acc;
  logic [2:0]  w_occ;
  logic [1:0]  w_slot;
  logic [31:0] w_target;

  assign w_valid  = (r_cnt != 2'd0);
  assign w_pop    = w_valid & ~i_StallF & ~i_PCSrcE;
  // rvalid with nothing outstanding is a protocol violation and is ignored
  assign w_rsp    = i_imem_rvalid & (r_inflight != 2'd0);
  assign w_push   = w_rsp & (r_drop == 2'd0) & ~i_PCSrcE;
  assign w_occ    = 3'(r_inflight) + 3'(r_cnt) - 3'(w_pop);
  assign w_slot   = r_cnt - 2'(w_pop);
  assign w_target = i_PCTargetE & 32'hFFFF_FFFC;

  assign o_imem_req  = ~reset & ~i_PCSrcE & (w_occ < 3'd2);
  assign o_imem_addr = r_pc_req;
  assign w_acc       = o_imem_req & i_imem_ready;

  assign o_InstrValidF = w_valid;
  assign o_InstrF      = w_valid ? r_fifo[0].instr : NOP_INSTR;
  assign o_PCF         = w_valid ? r_fifo[0].pc    : r_pc_resp;
  assign o_PCPlus4F    = o_PCF + 32'd4;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc_req   <= RESET_PC;
      r_pc_resp  <= RESET_PC;
      r_inflight <= 2'd0;
      r_drop     <= 2'd0;
      r_cnt      <= 2'd0;
      r_fifo[0]  <= '0;
      r_fifo[1]  <= '0;
    end else if (i_PCSrcE) begin
      // everything still outstanding after this cycle belongs to the old path
      r_pc_req   <= w_target;
      r_pc_resp  <= w_target;
      r_cnt      <= 2'd0;
      r_inflight <= r_inflight - 2'(w_rsp);
      r_drop     <= r_inflight - 2'(w_rsp);
    end else begin
      if (w_acc)
        r_pc_req <= r_pc_req + 32'd4;
      r_inflight <= r_inflight + 2'(w_acc) - 2'(w_rsp);
      if (w_rsp && r_drop != 2'd0)
        r_drop <= r_drop - 2'd1;
      if (w_push)
        r_pc_resp <= r_pc_resp + 32'd4;
      r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
      if (w_pop)
        r_fifo[0] <= r_fifo[1];
      // push lands in the first free slot after this cycle's pop
      if (w_push) begin
        if (w_slot == 2'd0) r_fifo[0] <= '{pc: r_pc_resp, instr: i_imem_rdata};
        else                r_fifo[1] <= '{pc: r_pc_resp, instr: i_imem_rdata};
      end
    end
  end

endmodule
